// File: rtl/riscy_pkg.sv
// Shared LSU types: RV32I load/store width codes, FSM state encoding, address helpers.
package riscy_pkg;

   typedef enum logic [2:0] {
      LS_B  = 3'b000,
      LS_H  = 3'b001,
      LS_W  = 3'b010,
      LS_BU = 3'b100,
      LS_HU = 3'b101
   } ls_width_e;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StResp
   } lsu_state_t;

   function automatic logic funct3_legal(input logic [2:0] f);
      case (f)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
      case (f)
         3'b001, 3'b101: return a[0];
         3'b010:         return |a;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] natural_align(input logic [2:0] f, input logic [31:0] a);
      case (f)
         3'b001, 3'b101: return {a[31:1], 1'b0};
         3'b010:         return {a[31:2], 2'b00};
         default:        return a;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store replication for the memory command,
// plus lane selection and sign/zero extension of load data.
module lsu_align
   import riscy_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] byte_shift;
   logic [31:0] half_shift;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_shift = rdata_i >> {addr_lo_i, 3'b000};
      half_shift = rdata_i >> {addr_lo_i[1], 4'b0000};
      byte_lane  = byte_shift[7:0];
      half_lane  = half_shift[15:0];
   end

   always_comb begin
      be_o    = 4'b0000;
      wdata_o = 32'h0;
      rdata_o = 32'h0;
      case (funct3_i)
         LS_B: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{byte_lane[7]}}, byte_lane};
         end
         LS_BU: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {24'h0, byte_lane};
         end
         LS_H: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{half_lane[15]}}, half_lane};
         end
         LS_HU: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {16'h0, half_lane};
         end
         LS_W: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
            rdata_o = rdata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: IDLE/REQ/WAIT/RESP handshake FSM with a WAIT timeout.
// Define LSU_MISALIGN_TRAP_EN to abort misaligned accesses instead of force-aligning them.
module lsu
   import riscy_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   lsu_state_t  state_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic [7:0]  cnt_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;

   logic [31:0] eff_addr;
   logic        req_abort;
   logic        sel_req;
   logic [2:0]  al_funct3;
   logic [1:0]  al_addr_lo;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
   assign eff_addr  = req_addr_i;
   assign req_abort = !funct3_legal(req_funct3_i) || misaligned(req_funct3_i, req_addr_i[1:0]);
`else
   assign eff_addr  = natural_align(req_funct3_i, req_addr_i);
   assign req_abort = !funct3_legal(req_funct3_i);
`endif

   // One align instance: fed by the incoming request in IDLE (command build),
   // by the captured request otherwise (load extraction in WAIT).
   assign sel_req    = (state_q == StIdle);
   assign al_funct3  = sel_req ? req_funct3_i : funct3_q;
   assign al_addr_lo = sel_req ? eff_addr[1:0] : addr_lo_q;

   lsu_align u_align (
      .funct3_i  (al_funct3),
      .addr_lo_i (al_addr_lo),
      .wdata_i   (req_wdata_i),
      .rdata_i   (mem_rdata_i),
      .be_o      (al_be),
      .wdata_o   (al_wdata),
      .rdata_o   (al_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         addr_lo_q    <= 2'b00;
         cnt_q        <= 8'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_be_q     <= 4'b0000;
         mem_wdata_q  <= 32'h0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  we_q        <= req_we_i;
                  funct3_q    <= req_funct3_i;
                  addr_lo_q   <= eff_addr[1:0];
                  req_ready_q <= 1'b0;
                  if (req_abort) begin
                     state_q      <= StResp;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
                  end else begin
                     state_q     <= StReq;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= req_we_i;
                     mem_addr_q  <= {eff_addr[31:2], 2'b00};
                     mem_be_q    <= al_be;
                     mem_wdata_q <= al_wdata;
                  end
               end
            end
            StReq: begin
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  cnt_q     <= 8'd0;
                  state_q   <= StWait;
               end
            end
            StWait: begin
               if (mem_rvalid_i) begin
                  state_q      <= StResp;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= we_q ? 32'h0 : al_rdata;
                  cnt_q        <= 8'd0;
               end else if (cnt_q == TimeoutLast) begin
                  state_q      <= StResp;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= 32'h0;
                  cnt_q        <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StResp: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'h0;
               req_ready_q  <= 1'b1;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_err_o   = resp_err_q;
   assign mem_req_o    = mem_req_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_be_o     = mem_be_q;
   assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: driver pushes expected memory commands and responses,
// a memory responder and a response monitor pop and compare independently.
module tb_lsu;
   import riscy_pkg::*;

   localparam int unsigned TO = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_gnt = 1'b0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_we_i     (req_we),
      .req_funct3_i (req_funct3),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid),
      .resp_rdata_o (resp_rdata),
      .resp_err_o   (resp_err),
      .mem_req_o    (mem_req),
      .mem_gnt_i    (mem_gnt),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_be_o     (mem_be),
      .mem_wdata_o  (mem_wdata),
      .mem_rvalid_i (mem_rvalid),
      .mem_rdata_i  (mem_rdata)
   );

   // mode: 0 normal completion, 1 rvalid withheld (timeout), 2 rvalid only after late_go
   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          mode;
   } cmd_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          issue_cyc;
      bit          chk_lat;
      int          lat;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   min_lat = 1'b1;
   bit   late_go = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
      chk({tag, "_resp_err"},   32'(resp_err),   32'd0);
      chk({tag, "_mem_req"},    32'(mem_req),    32'd0);
      chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
      chk({tag, "_mem_addr"},   mem_addr,        32'd0);
      chk({tag, "_mem_be"},     32'(mem_be),     32'd0);
      chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
   endtask

   // Reference model from access size arithmetic; call at a negedge.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int mode,
                        input bit chk_lat);
      int          size;
      int          lane;
      int          w;
      bit          legal;
      bit          trap;
      logic [31:0] eff;
      logic [31:0] v;
      logic [31:0] mask;
      logic [31:0] wrep;
      cmd_t        c;
      rsp_t        r;
      legal = 1'b1;
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default: begin
            size  = 4;
            legal = 1'b0;
         end
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      trap = 1'b1;
`else
      trap = 1'b0;
`endif
      w = 0;
      while (!req_ready && w < 1000) begin
         @(negedge clk);
         w++;
      end
      chk("issue_ready", 32'(req_ready), 32'd1);
      if (!req_ready) return;
      r.issue_cyc = cyc;
      r.chk_lat   = chk_lat;
      if (!legal || (trap && (addr % size) != 0)) begin
         r.rdata = 32'h0;
         r.err   = 1'b1;
         r.lat   = 1;
         rsp_q.push_back(r);
      end else begin
         eff  = addr - (addr % size);
         lane = int'(eff % 4);
         for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wdata[8*(i % size) +: 8];
         v = rdata >> (8 * lane);
         if (size < 4) begin
            mask = (32'd1 << (8 * size)) - 32'd1;
            v    = v & mask;
            if (f3[2] == 1'b0 && v[8*size-1]) v = v | ~mask;
         end
         c.addr  = eff - (eff % 4);
         c.be    = 4'(((1 << size) - 1) << lane);
         c.we    = we;
         c.wdata = wrep;
         c.rdata = rdata;
         c.mode  = mode;
         cmd_q.push_back(c);
         if (mode == 1) begin
            r.rdata = 32'h0;
            r.err   = 1'b1;
            r.lat   = int'(TO) + 2;
            rsp_q.push_back(r);
         end else if (mode == 0) begin
            r.rdata = we ? 32'h0 : v;
            r.err   = 1'b0;
            r.lat   = 3;
            rsp_q.push_back(r);
         end
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(negedge clk);
      req_valid  = 1'b0;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      chk("ready_low_busy", 32'(req_ready), 32'd0);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((rsp_q.size() != 0 || cmd_q.size() != 0) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", 32'(rsp_q.size() + cmd_q.size()), 32'd0);
   endtask

   // Memory responder
   initial begin
      cmd_t c;
      int   d;
      int   w;
      forever begin
         @(negedge clk);
         if (rst_n && mem_req) begin
            if (cmd_q.size() == 0) begin
               chk("mem_req_unexpected", 32'(mem_req), 32'd0);
               mem_gnt = 1'b1;
               @(negedge clk);
               mem_gnt = 1'b0;
            end else begin
               c = cmd_q.pop_front();
               chk("mem_addr", mem_addr, c.addr);
               chk("mem_be", 32'(mem_be), 32'(c.be));
               chk("mem_we", 32'(mem_we), 32'(c.we));
               if (c.we) chk("mem_wdata", mem_wdata, c.wdata);
               d = min_lat ? 0 : $urandom_range(0, 2);
               for (int k = 0; k < d; k++) begin
                  mem_rvalid = ($urandom_range(0, 3) == 0);
                  mem_rdata  = $urandom;
                  @(negedge clk);
                  chk("mem_req_held", 32'(mem_req), 32'd1);
                  chk("mem_addr_stable", mem_addr, c.addr);
                  chk("mem_be_stable", 32'(mem_be), 32'(c.be));
               end
               mem_rvalid = 1'b0;
               mem_gnt    = 1'b1;
               @(negedge clk);
               mem_gnt = 1'b0;
               chk("mem_req_drop", 32'(mem_req), 32'd0);
               if (c.mode == 0) begin
                  d = min_lat ? 0 : $urandom_range(0, 3);
                  repeat (d) @(negedge clk);
                  mem_rvalid = 1'b1;
                  mem_rdata  = c.rdata;
                  @(negedge clk);
                  mem_rvalid = 1'b0;
                  mem_rdata  = $urandom;
               end else if (c.mode == 2) begin
                  w = 0;
                  while (!late_go && w < 200) begin
                     @(negedge clk);
                     w++;
                  end
                  chk("late_go_seen", 32'(late_go), 32'd1);
                  mem_rvalid = 1'b1;
                  mem_rdata  = c.rdata;
                  @(negedge clk);
                  mem_rvalid = 1'b0;
               end
            end
         end
      end
   end

   // Response monitor
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (resp_valid) begin
               if (rsp_q.size() == 0) begin
                  chk("resp_unexpected", 32'(resp_valid), 32'd0);
               end else begin
                  r = rsp_q.pop_front();
                  chk("resp_rdata", resp_rdata, r.rdata);
                  chk("resp_err", 32'(resp_err), 32'(r.err));
                  if (r.chk_lat) chk("resp_latency", 32'(cyc - r.issue_cyc), 32'(r.lat));
               end
            end else begin
               chk("rdata_idle_zero", resp_rdata, 32'd0);
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got no end of test, expected finish before cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] legal_tab[5];
      logic [2:0] illegal_tab[3];
      logic [2:0] f3;
      int         k;
      int         mode;
      legal_tab   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      illegal_tab = '{3'b011, 3'b110, 3'b111};

      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;

      // Directed, zero-wait memory
      issue(1'b1, LS_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1'b1);
      issue(1'b0, LS_B,  32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1'b1);
      issue(1'b0, LS_BU, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1'b1);
      issue(1'b1, LS_H,  32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 1'b1);
      issue(1'b0, LS_W,  32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0, 1'b1);
      issue(1'b0, LS_HU, 32'h0000_0302, 32'h0, 32'h9876_5432, 0, 1'b1);
      issue(1'b0, 3'b011, 32'h0000_0400, 32'h0, 32'h0, 0, 1'b1);
      issue(1'b0, LS_W,  32'h0000_0300, 32'h0, 32'h1111_2222, 1, 1'b1);
      drain();
      @(negedge clk);
      chk("ready_after_timeout", 32'(req_ready), 32'd1);

      // Reset while waiting for read data; late rvalid must be ignored
      issue(1'b0, LS_W, 32'h0000_0500, 32'h0, 32'h5555_AAAA, 2, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_wait");
      @(negedge clk);
      rst_n   = 1'b1;
      late_go = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk_reset_vals("post_rst");
      end
      late_go = 1'b0;
      drain();

      // Randomized traffic with random grant/rvalid delays
      min_lat = 1'b0;
      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 19);
         f3 = (k < 17) ? legal_tab[k % 5] : illegal_tab[k - 17];
         mode = ($urandom_range(0, 15) == 0) ? 1 : 0;
         issue(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom, mode, 1'b0);
      end
      drain();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT, 64, max cycles in WAIT before abort with error; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid / req_ready  in / out  1 / 1  request handshake from execute stage; transfer when both high.
REQ-005 req_we  in  1  1=store, 0=load.
REQ-006 req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 req_addr  in  32  effective address (ALU rd output).
REQ-008 req_wdata  in  32  store data (rs2), right-aligned.
REQ-009 resp_valid / resp_rdata / resp_err  out  1 / 32 / 1  one-cycle result pulse to writeback.
REQ-010 mem_req / mem_gnt  out / in  1 / 1  memory request handshake.
REQ-011 mem_we / mem_addr / mem_be / mem_wdata  out  1 / 32 / 4 / 32  word-aligned memory command.
REQ-012 mem_rvalid / mem_rdata  in  1 / 32  memory completion; accepted for loads and stores.

Function
REQ-013 FSM states IDLE, REQ, WAIT, RESP; req_ready SHALL be high only in IDLE.
REQ-014 IDLE: on req_valid, capture all request fields into registers; go to REQ next cycle; illegal funct3 (011,110,111) goes to RESP with resp_err=1, no memory access.
REQ-015 REQ: mem_req=1, command stable until mem_gnt; mem_gnt=1 -> WAIT.
REQ-016 WAIT: mem_rvalid=1 -> RESP; counter reaching TIMEOUT without rvalid -> RESP with resp_err=1.
REQ-017 RESP: resp_valid=1 for exactly one cycle, then IDLE; minimum accept-to-resp_valid latency 3 cycles with gnt and rvalid same-cycle-as-asked.
REQ-018 mem_addr = {addr[31:2],2'b00}; mem_be: B=0001<<addr[1:0], H=0011<<{addr[1],0}, W=1111.
REQ-019 mem_wdata: byte replicated x4, halfword replicated x2, word as-is.
REQ-020 Load data: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend; stores return resp_rdata=0.
REQ-021 Misaligned: H with addr[0]=1, W with addr[1:0]!=0; behaviour per REQ-026/027.
REQ-022 mem_rvalid outside WAIT SHALL be ignored; resp_rdata SHALL be 0 whenever resp_valid=0.

Reset
REQ-023 rst_n low SHALL force IDLE immediately, mid-transaction included; outstanding memory response discarded.
REQ-024 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, timeout counter=0.
REQ-025 First request SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-026 With LSU_MISALIGN_TRAP_EN defined: misaligned request goes IDLE->RESP, resp_err=1, no mem_req asserted.
REQ-027 Without LSU_MISALIGN_TRAP_EN: addr low bits forced to natural alignment (H clears bit0, W clears bits1:0), access proceeds, resp_err=0.

Structure
REQ-028 Shared package riscy_pkg SHALL hold funct3 width enum (LS_B, LS_H, LS_W, LS_BU, LS_HU) and lsu_state_t enum.
REQ-029 Sub-module lsu_align (combinational: mem_be, mem_wdata, load extraction/extension) SHALL be instantiated by lsu; FSM and timeout counter in lsu.

Verification
REQ-030 Store word addr=0x100, wdata=0xDEADBEEF -> mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF, resp_err=0, resp_rdata=0.
REQ-031 Load B addr=0x103, mem_rdata=0x80112233 -> be=1000, resp_rdata=0xFFFFFF80; same as BU -> 0x00000080.
REQ-032 Store H addr=0x202, wdata=0x1234ABCD -> be=1100, mem_wdata=0xABCDABCD.
REQ-033 Load W addr=0x101 -> with macro: resp_err=1, mem_req never asserted; without: mem_addr=0x100, resp_err=0.
REQ-034 Load W, mem_gnt=1, mem_rvalid withheld TIMEOUT cycles -> resp_valid=1, resp_err=1, back to IDLE (req_ready=1) next cycle.
REQ-035 rst_n pulsed low in WAIT, late mem_rvalid after release -> no resp_valid, req_ready=1, all outputs at reset values.
